// File: rtl/alu_op_sequencer.sv
// Issue/retire controller between ALU decode and the ALU / register-file write port.
// Optional macro ALU_SEQ_DIVZ_EN adds a div_zero input that aborts a div in EXEC.
module alu_op_sequencer #(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 8,
   parameter int RA_W        = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            op_valid,
   output logic            op_ready,
   input  logic [3:0]      operation,
   input  logic [RA_W-1:0] rd,
   input  logic [RA_W-1:0] rs,
`ifdef ALU_SEQ_DIVZ_EN
   input  logic            div_zero,
`else
`endif
   output logic            alu_start,
   output logic [3:0]      alu_op,
   output logic            wb_en,
   output logic [RA_W-1:0] wb_addr,
   output logic            wb_sel,
   output logic            done,
   output logic            illegal,
   output logic            busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_WAIT,
      S_WB,
      S_WB2,
      S_RETIRE
   } state_t;

   localparam logic [3:0] OP_MULT = 4'b0011;
   localparam logic [3:0] OP_DIV  = 4'b0100;
   localparam logic [3:0] OP_SWAP = 4'b0110;
   localparam logic [3:0] OP_NOP  = 4'b1111;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 2);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 2);

   function automatic logic is_undef(input logic [3:0] code);
      return (code == 4'b0000) || ((code >= 4'b1000) && (code <= 4'b1110));
   endfunction

   state_t            r_state, w_next;
   logic [3:0]        r_cnt, w_cnt_next;
   logic [3:0]        r_op;
   logic [RA_W-1:0]   r_rd, r_rs;
   logic              w_accept;
   logic              w_abort;

   assign w_accept = (r_state == S_IDLE) && op_valid;

`ifdef ALU_SEQ_DIVZ_EN
   assign w_abort = (r_op == OP_DIV) && div_zero;
`else
   assign w_abort = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_rd    <= '0;
         r_rs    <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_op <= operation;
            r_rd <= rd;
            r_rs <= rs;
         end
      end
   end

   // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (op_valid)
               w_next = ((operation == OP_NOP) || is_undef(operation)) ? S_RETIRE : S_EXEC;
         end
         S_EXEC: begin
            if (w_abort) begin
               w_next = S_RETIRE;
            end else if (r_op == OP_MULT) begin
               w_cnt_next = MULT_LOAD;
               w_next     = S_WAIT;
            end else if (r_op == OP_DIV) begin
               w_cnt_next = DIV_LOAD;
               w_next     = S_WAIT;
            end else begin
               w_next = S_WB;
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) w_next = S_WB;
            else               w_cnt_next = r_cnt - 4'd1;
         end
         S_WB:     w_next = (r_op == OP_SWAP) ? S_WB2 : S_IDLE;
         S_WB2:    w_next = S_IDLE;
         S_RETIRE: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Outputs depend only on state and latched fields, never on the request inputs.
   always_comb begin
      op_ready  = (r_state == S_IDLE);
      busy      = (r_state != S_IDLE);
      alu_start = (r_state == S_EXEC);
      alu_op    = r_op;
      wb_en     = (r_state == S_WB) || (r_state == S_WB2);
      wb_sel    = (r_state == S_WB2);
      wb_addr   = '0;
      if (r_state == S_WB)  wb_addr = r_rd;
      if (r_state == S_WB2) wb_addr = r_rs;
      done      = (r_state == S_RETIRE) || (r_state == S_WB2) ||
                  ((r_state == S_WB) && (r_op != OP_SWAP));
      // Only an aborted div reaches RETIRE with the div code latched.
      illegal   = (r_state == S_RETIRE) && (is_undef(r_op) || (r_op == OP_DIV));
   end

endmodule
